set_button_ctrl: RTL and testbench

Front-end conditioner for the alarm-clock user buttons. It synchronizes and debounces five raw push-buttons and runs the run/time-set/alarm-set mode FSM. It generates the Timeset/Alarmset mode levels and the single-cycle Minadv/Hrsadv/Dayadv advance strobes that the clock top level consumes. Advance strobes auto-repeat while a button is held.

---
 rtl/set_button_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_set_button_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : set_button_ctrl
// Brief   : Synchronizes and debounces the five alarm-clock buttons, runs the
//           RUN/TSET/ASET mode FSM and issues auto-repeating advance strobes.
// Rev     : 1.0  initial release
// ============================================================================
module set_button_ctrl #(
  parameter int DB      = 3,
  parameter int RPT_DLY = 8,
  parameter int RPT_INT = 2,
  parameter int TO      = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_time,
  input  logic btn_alarm,
  input  logic btn_min,
  input  logic btn_hrs,
  input  logic btn_day,
  output logic Timeset,
  output logic Alarmset,
  output logic Minadv,
  output logic Hrsadv,
  output logic Dayadv
);

  localparam int c_NBTN    = 5;
  localparam int c_NADV    = 3;
  localparam int c_BT      = 0;
  localparam int c_BA      = 1;
  localparam int c_BADV0   = 2;
  localparam int c_DBW     = $clog2(DB + 1);
  localparam int c_RPT_MAX = (RPT_DLY > RPT_INT) ? RPT_DLY : RPT_INT;
  localparam int c_RW      = $clog2(c_RPT_MAX + 1);
  localparam int c_TW      = $clog2(TO + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TSET = 2'd1,
    ST_ASET = 2'd2
  } state_t;

  logic [c_NBTN-1:0] w_raw;
  logic [c_NBTN-1:0] r_sync1;
  logic [c_NBTN-1:0] r_sync2;
  logic [c_NBTN-1:0] w_deb;
  logic [c_NBTN-1:0] r_deb_d;
  logic [c_NBTN-1:0] w_press;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_change;
  logic              w_timeout;
  logic              w_to_clr;
  logic [c_TW-1:0]   r_to;
  logic [c_NADV-1:0] w_adv_ok;
  logic [c_NADV-1:0] w_stb;

  assign w_raw = {btn_day, btn_hrs, btn_min, btn_alarm, btn_time};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb_d <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= w_deb;
    end
  end

  assign w_press = w_deb & ~r_deb_d;

  generate
    for (genvar gi = 0; gi < c_NBTN; gi++) begin : g_dbnc
      logic [c_DBW-1:0] r_cnt;
      logic             r_db;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_sync2[gi] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DBW'(DB - 1)) begin
          r_cnt <= '0;
          r_db  <= ~r_db;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_deb[gi] = r_db;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A time press always outranks an alarm press arriving in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_press[c_BT])      w_state_nxt = ST_TSET;
        else if (w_press[c_BA]) w_state_nxt = ST_ASET;
      end
      ST_TSET: begin
        if (w_press[c_BT])      w_state_nxt = ST_RUN;
        else if (w_press[c_BA]) w_state_nxt = ST_ASET;
        else if (w_timeout)     w_state_nxt = ST_RUN;
      end
      ST_ASET: begin
        if (w_press[c_BT])      w_state_nxt = ST_TSET;
        else if (w_press[c_BA]) w_state_nxt = ST_RUN;
        else if (w_timeout)     w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_change = (w_state_nxt != r_state);

  // Every advance strobe needs its button debounced-high, so the held-button
  // term alone covers the strobe clear and keeps this path loop-free.
  assign w_to_clr  = |w_deb[c_NBTN-1:c_BADV0];
  assign w_timeout = (r_state != ST_RUN) && !w_to_clr && (r_to == c_TW'(TO - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to <= '0;
    end else if ((w_state_nxt == ST_RUN) || w_change || w_to_clr) begin
      r_to <= '0;
    end else begin
      r_to <= r_to + 1'b1;
    end
  end

  assign w_adv_ok[0] = (r_state != ST_RUN);
  assign w_adv_ok[1] = (r_state != ST_RUN);
  assign w_adv_ok[2] = (r_state == ST_TSET);

  generate
    for (genvar gi = 0; gi < c_NADV; gi++) begin : g_adv
      logic [c_RW-1:0] r_rpt;
      logic            r_first;
      logic [c_RW-1:0] w_target;
      logic            w_fire;

      assign w_target = r_first ? c_RW'(RPT_DLY) : c_RW'(RPT_INT);
      assign w_fire   = w_deb[c_BADV0+gi] && !w_press[c_BADV0+gi] && (r_rpt == w_target);
      assign w_stb[gi] = (w_press[c_BADV0+gi] || w_fire) && w_adv_ok[gi] && !w_change;

      // A mode change restarts the long delay exactly as a fresh press would.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_rpt   <= '0;
          r_first <= 1'b1;
        end else if (!w_deb[c_BADV0+gi]) begin
          r_rpt   <= '0;
          r_first <= 1'b1;
        end else if (w_press[c_BADV0+gi] || w_change) begin
          r_rpt   <= c_RW'(1);
          r_first <= 1'b1;
        end else if (w_fire) begin
          r_rpt   <= c_RW'(1);
          r_first <= 1'b0;
        end else begin
          r_rpt   <= r_rpt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      Timeset  <= 1'b0;
      Alarmset <= 1'b0;
      Minadv   <= 1'b0;
      Hrsadv   <= 1'b0;
      Dayadv   <= 1'b0;
    end else begin
      Timeset  <= (r_state == ST_TSET);
      Alarmset <= (r_state == ST_ASET);
      Minadv   <= w_stb[0];
      Hrsadv   <= w_stb[1];
      Dayadv   <= w_stb[2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_set_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_set_button_ctrl
// Brief   : Scoreboard bench for set_button_ctrl with default parameters.
// Rev     : 1.0  initial release
// ============================================================================
module tb_set_button_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_time = 1'b0, btn_alarm = 1'b0, btn_min = 1'b0, btn_hrs = 1'b0, btn_day = 1'b0;
  logic Timeset, Alarmset, Minadv, Hrsadv, Dayadv;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  int exp_min[$], exp_hrs[$], exp_day[$];
  int obs_min[$], obs_hrs[$], obs_day[$];
  int rd_min = 0, rd_hrs = 0, rd_day = 0;

  set_button_ctrl #(.DB(3), .RPT_DLY(8), .RPT_INT(2), .TO(30)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .btn_time (btn_time),
    .btn_alarm(btn_alarm),
    .btn_min  (btn_min),
    .btn_hrs  (btn_hrs),
    .btn_day  (btn_day),
    .Timeset  (Timeset),
    .Alarmset (Alarmset),
    .Minadv   (Minadv),
    .Hrsadv   (Hrsadv),
    .Dayadv   (Dayadv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobes are logged by cycle; the tests pop them against expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Minadv === 1'b1) obs_min.push_back(cyc);
      if (Hrsadv === 1'b1) obs_hrs.push_back(cyc);
      if (Dayadv === 1'b1) obs_day.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    {btn_time, btn_alarm, btn_min, btn_hrs, btn_day} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic enter_mode(input bit alarm, output int base);
    if (alarm) btn_alarm = 1'b1;
    else       btn_time  = 1'b1;
    base = cyc + 1;
    wait_cyc(base + 6);
    btn_alarm = 1'b0;
    btn_time  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({Timeset, Alarmset} !== 2'b00) begin
      bad++;
      $display("FAIL reset_modes got=%b want=00", {Timeset, Alarmset});
    end
    total++;
    if ({Minadv, Hrsadv, Dayadv} !== 3'b000) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=000", {Minadv, Hrsadv, Dayadv});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_mode_entry();
    int b;
    btn_time = 1'b1;
    b = cyc + 1;
    wait_cyc(b + 5);
    total++;
    if (Timeset !== 1'b0) begin
      bad++;
      $display("FAIL entry_early cycle=5 got=%b want=0", Timeset);
    end
    wait_cyc(b + 6);
    total++;
    if ({Timeset, Alarmset} !== 2'b10) begin
      bad++;
      $display("FAIL entry_tset cycle=6 got=%b want=10", {Timeset, Alarmset});
    end
    btn_time = 1'b0;
  endtask

  task automatic test_debounce();
    int b, p, want;
    apply_reset();
    enter_mode(1'b0, b);
    btn_min = 1'b1;
    repeat (2) @(negedge clk);
    btn_min = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (obs_min.size() != rd_min) begin
      bad++;
      $display("FAIL glitch_min got=%0d strobes want=0", obs_min.size() - rd_min);
    end
    btn_min = 1'b1;
    p = cyc + 1;
    exp_min.push_back(p + 5);
    wait_cyc(p + 5);
    btn_min = 1'b0;
    wait_cyc(p + 20);
    while (exp_min.size() > 0) begin
      want = exp_min.pop_front();
      total++;
      if (rd_min >= obs_min.size()) begin
        bad++;
        $display("FAIL press_min got=none want_cycle=%0d", want);
      end else begin
        if (obs_min[rd_min] != want) begin
          bad++;
          $display("FAIL press_min got_cycle=%0d want_cycle=%0d", obs_min[rd_min], want);
        end
        rd_min++;
      end
    end
    total++;
    if (obs_min.size() != rd_min) begin
      bad++;
      $display("FAIL press_min_extra got=%0d extra want=0", obs_min.size() - rd_min);
      rd_min = obs_min.size();
    end
  endtask

  task automatic test_repeat();
    int b, p, want;
    int offs[7] = '{5, 13, 15, 17, 19, 21, 23};
    apply_reset();
    enter_mode(1'b0, b);
    btn_hrs = 1'b1;
    p = cyc + 1;
    foreach (offs[i]) exp_hrs.push_back(p + offs[i]);
    wait_cyc(p + 19);
    btn_hrs = 1'b0;
    wait_cyc(p + 32);
    while (exp_hrs.size() > 0) begin
      want = exp_hrs.pop_front();
      total++;
      if (rd_hrs >= obs_hrs.size()) begin
        bad++;
        $display("FAIL repeat_hrs got=none want_cycle=%0d", want);
      end else begin
        if (obs_hrs[rd_hrs] != want) begin
          bad++;
          $display("FAIL repeat_hrs got_cycle=%0d want_cycle=%0d", obs_hrs[rd_hrs], want);
        end
        rd_hrs++;
      end
    end
    total++;
    if (obs_hrs.size() != rd_hrs) begin
      bad++;
      $display("FAIL repeat_hrs_extra got=%0d extra want=0", obs_hrs.size() - rd_hrs);
      rd_hrs = obs_hrs.size();
    end
  endtask

  task automatic test_mode_gate();
    int b, p1, t, want;
    apply_reset();
    enter_mode(1'b1, b);
    total++;
    if ({Timeset, Alarmset} !== 2'b01) begin
      bad++;
      $display("FAIL gate_aset got=%b want=01", {Timeset, Alarmset});
    end
    btn_day = 1'b1;
    p1 = cyc;
    wait_cyc(p1 + 12);
    btn_time = 1'b1;
    t = cyc + 1;
    exp_day.push_back(t + 13);
    exp_day.push_back(t + 15);
    exp_day.push_back(t + 17);
    exp_day.push_back(t + 19);
    wait_cyc(t + 6);
    btn_time = 1'b0;
    total++;
    if ({Timeset, Alarmset} !== 2'b10) begin
      bad++;
      $display("FAIL gate_tset got=%b want=10", {Timeset, Alarmset});
    end
    wait_cyc(t + 14);
    btn_day = 1'b0;
    wait_cyc(t + 30);
    while (exp_day.size() > 0) begin
      want = exp_day.pop_front();
      total++;
      if (rd_day >= obs_day.size()) begin
        bad++;
        $display("FAIL gate_day got=none want_cycle=%0d", want);
      end else begin
        if (obs_day[rd_day] != want) begin
          bad++;
          $display("FAIL gate_day got_cycle=%0d want_cycle=%0d", obs_day[rd_day], want);
        end
        rd_day++;
      end
    end
    total++;
    if (obs_day.size() != rd_day) begin
      bad++;
      $display("FAIL gate_day_extra got=%0d extra want=0", obs_day.size() - rd_day);
      rd_day = obs_day.size();
    end
  endtask

  task automatic test_simultaneous();
    int b;
    apply_reset();
    btn_time  = 1'b1;
    btn_alarm = 1'b1;
    b = cyc + 1;
    wait_cyc(b + 6);
    btn_time  = 1'b0;
    btn_alarm = 1'b0;
    total++;
    if ({Timeset, Alarmset} !== 2'b10) begin
      bad++;
      $display("FAIL simul_modes got=%b want=10", {Timeset, Alarmset});
    end
    wait_cyc(b + 12);
    total++;
    if ({Timeset, Alarmset} !== 2'b10) begin
      bad++;
      $display("FAIL simul_stable got=%b want=10", {Timeset, Alarmset});
    end
  endtask

  task automatic test_timeout();
    int b, e, p, want;
    apply_reset();
    enter_mode(1'b1, b);
    e = b + 6;
    wait_cyc(e + 29);
    total++;
    if (Alarmset !== 1'b1) begin
      bad++;
      $display("FAIL timeout_hold cycle=29 got=%b want=1", Alarmset);
    end
    wait_cyc(e + 30);
    total++;
    if ({Timeset, Alarmset} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_drop cycle=30 got=%b want=00", {Timeset, Alarmset});
    end

    apply_reset();
    enter_mode(1'b1, b);
    e = b + 6;
    wait_cyc(e + 14);
    btn_min = 1'b1;
    p = cyc + 1;
    exp_min.push_back(p + 5);
    wait_cyc(p + 3);
    btn_min = 1'b0;
    wait_cyc(e + 53);
    total++;
    if (Alarmset !== 1'b1) begin
      bad++;
      $display("FAIL timeout_ext_hold cycle=53 got=%b want=1", Alarmset);
    end
    wait_cyc(e + 54);
    total++;
    if (Alarmset !== 1'b0) begin
      bad++;
      $display("FAIL timeout_ext_drop cycle=54 got=%b want=0", Alarmset);
    end
    while (exp_min.size() > 0) begin
      want = exp_min.pop_front();
      total++;
      if (rd_min >= obs_min.size()) begin
        bad++;
        $display("FAIL timeout_min got=none want_cycle=%0d", want);
      end else begin
        if (obs_min[rd_min] != want) begin
          bad++;
          $display("FAIL timeout_min got_cycle=%0d want_cycle=%0d", obs_min[rd_min], want);
        end
        rd_min++;
      end
    end
    total++;
    if (obs_min.size() != rd_min) begin
      bad++;
      $display("FAIL timeout_min_extra got=%0d extra want=0", obs_min.size() - rd_min);
      rd_min = obs_min.size();
    end
  endtask

  initial begin
    test_reset();
    test_mode_entry();
    test_debounce();
    test_repeat();
    test_mode_gate();
    test_simultaneous();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
